// File: rtl/multiplier_if.sv
// Operand/handshake bundle for the shift-and-add multiplier.
// The master drives the operands and the start level; the slave returns P and Done.
interface multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 s;
   logic                 LA;
   logic                 EB;
   logic [WIDTH-1:0]     DataA;
   logic [WIDTH-1:0]     DataB;
   logic [2*WIDTH-1:0]   P;
   logic                 Done;

   modport master (
      output s, LA, EB, DataA, DataB,
      input  P, Done
   );

   modport slave (
      input  s, LA, EB, DataA, DataB,
      output P, Done
   );
endinterface

// File: rtl/multiplier.sv
// Sequential shift-and-add multiplier with load/start/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product (default: unsigned).
module multiplier #(
   parameter int WIDTH = 8
) (
   input  logic         Clock,
   input  logic         Reset,
   multiplier_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [2*WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   p_q, p_d;

   // Operand values as seen on this edge: a load in S_IDLE is used at once by a same-edge start.
   logic [2*WIDTH-1:0]   a_ld;
   logic [WIDTH-1:0]     b_ld;

`ifdef MULT_SIGNED_EN
   logic                 sign_q, sign_d;

   // -2^(WIDTH-1) maps onto itself, which read as unsigned is the correct magnitude.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
   endfunction
`endif

   always_comb begin
      a_ld = bus.LA ? {{WIDTH{1'b0}}, bus.DataA} : a_q;
      b_ld = bus.EB ? bus.DataB : b_q;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
`ifdef MULT_SIGNED_EN
      sign_d  = sign_q;
`endif
      case (state_q)
         S_IDLE: begin
            a_d = a_ld;
            b_d = b_ld;
            if (bus.s) begin
               p_d     = '0;
               state_d = S_MUL;
`ifdef MULT_SIGNED_EN
               a_d     = {{WIDTH{1'b0}}, mag(a_ld[WIDTH-1:0])};
               b_d     = mag(b_ld);
               sign_d  = a_ld[WIDTH-1] ^ b_ld[WIDTH-1];
`endif
            end
         end
         S_MUL: begin
            if (b_q == '0) begin
               state_d = S_DONE;
`ifdef MULT_SIGNED_EN
               p_d     = sign_q ? -p_q : p_q;
`endif
            end else begin
               if (b_q[0]) p_d = p_q + a_q;
               a_d = a_q << 1;
               b_d = b_q >> 1;
            end
         end
         S_DONE: begin
            if (!bus.s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
`ifdef MULT_SIGNED_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
`ifdef MULT_SIGNED_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign bus.P    = p_q;
   assign bus.Done = (state_q == S_DONE);

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for multiplier: a spec-level product/latency model checked every cycle,
// plus literal expectations per vector. Build with MULT_SIGNED_EN for the signed variant.
module tb_multiplier;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   multiplier_if #(.WIDTH(8)) bus ();

   multiplier #(.WIDTH(8)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   // ---------------- model ----------------
   logic [7:0]  m_a, m_b;
   logic [15:0] m_p, m_res;
   int          m_ph;   // 0 idle, 1 busy, 2 done
   int          m_cnt;

   function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
      int r;
`ifdef MULT_SIGNED_EN
      r = int'($signed(a)) * int'($signed(b));
`else
      r = int'(a) * int'(b);
`endif
      return r[15:0];
   endfunction

   function automatic int lat_of(input logic [7:0] b);
      logic [7:0] bm;
      int         msb;
      int         nb;
      bm = b;
`ifdef MULT_SIGNED_EN
      nb = -int'($signed(b));
      if (b[7]) bm = nb[7:0];
`endif
      msb = -1;
      for (int i = 0; i < 8; i++) if (bm[i]) msb = i;
      return (msb < 0) ? 1 : msb + 2;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_a <= '0; m_b <= '0; m_p <= '0; m_res <= '0; m_ph <= 0; m_cnt <= 0;
      end else begin
         case (m_ph)
            0: begin
               if (bus.LA) m_a <= bus.DataA;
               if (bus.EB) m_b <= bus.DataB;
               if (bus.s) begin
                  m_ph  <= 1;
                  m_cnt <= lat_of(bus.EB ? bus.DataB : m_b);
                  m_res <= prod(bus.LA ? bus.DataA : m_a, bus.EB ? bus.DataB : m_b);
               end
            end
            1: begin
               if (m_cnt == 1) begin
                  m_ph <= 2;
                  m_p  <= m_res;
               end else m_cnt <= m_cnt - 1;
            end
            default: if (!bus.s) m_ph <= 0;
         endcase
      end
   end

   // Per-cycle compare; P is only meaningful outside the busy phase.
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (bus.Done !== (m_ph == 2)) begin
            errors++;
            $display("FAIL model_done t=%0t got %b want %b", $time, bus.Done, (m_ph == 2));
         end
         if (m_ph != 1) begin
            checks++;
            if (bus.P !== m_p) begin
               errors++;
               $display("FAIL model_p t=%0t got %h want %h", $time, bus.P, m_p);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!bus.Done && n < 40) begin
         tick();
         n++;
      end
   endtask

   // Loads on one edge, starts on the next, leaves s high in S_DONE.
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int exp_lat);
      int n;
      bus.LA = 1'b1; bus.EB = 1'b1; bus.DataA = a; bus.DataB = b; bus.s = 1'b0;
      tick();
      bus.LA = 1'b0; bus.EB = 1'b0; bus.s = 1'b1;
      tick();
      wait_done(n);
      chk({name, "_lat"}, n, exp_lat);
      chk({name, "_p"}, int'(bus.P), int'(exp_p));
   endtask

   task automatic release_s();
      bus.s = 1'b0;
      tick();
      chk("release_done", int'(bus.Done), 0);
   endtask

   logic [15:0] held;
   int          n;

   initial begin
      bus.s = 1'b0; bus.LA = 1'b0; bus.EB = 1'b0; bus.DataA = '0; bus.DataB = '0;
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      rst = 1'b0;
      chk("reset_p", int'(bus.P), 0);
      chk("reset_done", int'(bus.Done), 0);

`ifdef MULT_SIGNED_EN
      run_op("ff_a7", 8'hFF, 8'hA7, 16'h0059, 8);
`else
      run_op("ff_a7", 8'hFF, 8'hA7, 16'hA659, 9);
`endif
      held = bus.P;
      // Hold s high in S_DONE; a load attempt here must not disturb anything.
      for (int i = 0; i < 20; i++) begin
         bus.LA = (i == 5); bus.DataA = 8'h01;
         tick();
      end
      bus.LA = 1'b0;
      chk("hold_done", int'(bus.Done), 1);
      chk("hold_p", int'(bus.P), int'(held));
      release_s();
      chk("release_p", int'(bus.P), int'(held));

      // Same-edge load and start with a zero multiplier.
      bus.LA = 1'b1; bus.EB = 1'b1; bus.DataA = 8'h5A; bus.DataB = 8'h00; bus.s = 1'b1;
      tick();
      bus.LA = 1'b0; bus.EB = 1'b0;
      wait_done(n);
      chk("zero_lat", n, 1);
      chk("zero_p", int'(bus.P), 0);
      release_s();

      // Loads pulsed during S_MUL are ignored.
      bus.LA = 1'b1; bus.EB = 1'b1; bus.DataA = 8'h12; bus.DataB = 8'h34; bus.s = 1'b1;
      tick();
      bus.LA = 1'b0; bus.EB = 1'b0;
      tick();
      tick();
      bus.LA = 1'b1; bus.EB = 1'b1; bus.DataA = 8'h01; bus.DataB = 8'hFF;
      tick();
      bus.LA = 1'b0; bus.EB = 1'b0;
      wait_done(n);
      chk("mul_load_lat", n + 3, 7);
      chk("mul_load_p", int'(bus.P), 16'h03A8);
      release_s();

      // Reset in the middle of an operation.
      bus.LA = 1'b1; bus.EB = 1'b1; bus.DataA = 8'hFF; bus.DataB = 8'hFF; bus.s = 1'b1;
      tick();
      bus.LA = 1'b0; bus.EB = 1'b0;
      tick();
      tick();
      rst = 1'b1; bus.s = 1'b0;
      tick();
      chk("midrst_p", int'(bus.P), 0);
      chk("midrst_done", int'(bus.Done), 0);
      rst = 1'b0;
      run_op("after_rst", 8'h03, 8'h04, 16'h000C, 4);
      release_s();

`ifdef MULT_SIGNED_EN
      run_op("fe_03", 8'hFE, 8'h03, 16'hFFFA, 3);
      release_s();
      run_op("80_80", 8'h80, 8'h80, 16'h4000, 9);
      release_s();
      run_op("7f_81", 8'h7F, 8'h81, 16'hC0FF, 8);
      release_s();
`else
      run_op("fe_03", 8'hFE, 8'h03, 16'h02FA, 3);
      release_s();
      run_op("80_80", 8'h80, 8'h80, 16'h4000, 9);
      release_s();
      run_op("7f_81", 8'h7F, 8'h81, 16'h3FFF, 9);
      release_s();
`endif
      run_op("01_01", 8'h01, 8'h01, 16'h0001, 2);
      release_s();

      tick();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
